// File: rtl/uart_echo_responder.sv
// uart_echo_responder
//   Far-end loopback peer for a Uart8 link. Every good byte received on the
//   Uart8 receive interface is queued in a small FIFO and replayed out through
//   the Uart8 transmit interface, one byte per transmission.
//
// Ports
//   clk        system clock, rising edge
//   rstN       asynchronous active-low reset
//   en         responder enable; low flushes the FIFO and idles the block
//   rxDone     Uart8 rxDone; rising edge marks a completed byte
//   rxErr      Uart8 rxErr; sampled with the rxDone rising edge
//   rxByte     Uart8 received byte; valid with the rxDone rising edge
//   txBusy     Uart8 txBusy; falling edge marks transmit completion
//   txDone     Uart8 txDone; monitor only, not used for sequencing
//   txStart    Uart8 txStart request
//   txByte     byte presented to Uart8; stable in START and SEND
//   fifoCount  FIFO occupancy
//   overflow   sticky: a good byte was dropped because the FIFO was full
//   errCount   saturating count of bad receptions and abandoned starts
//   stateDbg   FSM state (IDLE=0, START=1, SEND=2, GAP=3)
//
// Handshake: txStart is a level request held from the pop until Uart8 shows
// txBusy high (or START_WAIT cycles pass); txByte is held until txBusy falls.
module uart_echo_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int START_WAIT = 2500,
  parameter int GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          en,
  input  logic                          rxDone,
  input  logic                          rxErr,
  input  logic [7:0]                    rxByte,
  input  logic                          txBusy,
  input  logic                          txDone,
  output logic                          txStart,
  output logic [7:0]                    txByte,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow,
  output logic [7:0]                    errCount,
  output logic [1:0]                    stateDbg
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(START_WAIT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rx_done_q, tx_busy_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_q, err_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic rx_rise, tx_fall, good, push, pop, drop, timeout;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  // txDone is informational only; completion is taken from the txBusy fall.
  logic unused_tx_done;
  assign unused_tx_done = txDone;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_start_d = tx_start_q;
    tx_byte_d  = tx_byte_q;
    overflow_d = overflow_q;
    wait_d     = wait_q;
    gap_d      = gap_q;
    timeout    = 1'b0;

    rx_rise = rxDone & ~rx_done_q;
    tx_fall = tx_busy_q & ~txBusy;
    pop     = en && (state_q == IDLE) && (count_q != '0);
    good    = en & rx_rise & ~rxErr;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push    = good && ((count_q != DEPTH_C) || pop);
    drop    = good && !push;

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_byte_d  = mem[rd_ptr_q];
          tx_start_d = 1'b1;
          wait_d     = '0;
          state_d    = START;
        end
      end
      START: begin
        if (txBusy) begin
          tx_start_d = 1'b0;
          state_d    = SEND;
        end else if (wait_q == WW'(START_WAIT - 1)) begin
          // Uart8 never acknowledged: abandon the byte and count it.
          tx_start_d = 1'b0;
          state_d    = IDLE;
          timeout    = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      SEND: begin
        if (tx_fall) begin
          gap_d   = GW'(GAP_CYCLES);
          state_d = GAP;
        end
      end
      default: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
    endcase

    // Power-of-two depth lets the pointers wrap naturally.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;

    // Bad reception and abandoned start can coincide; saturate the sum.
    err_inc = {1'b0, en & rx_rise & rxErr} + {1'b0, en & timeout};
    err_sum = {1'b0, err_q} + {7'd0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

    if (!en) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      tx_start_d = 1'b0;
      overflow_d = 1'b0;
      wait_d     = '0;
      gap_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      rx_done_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
      err_q      <= '0;
      wait_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_done_q  <= rxDone;
      tx_busy_q  <= txBusy;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      gap_q      <= gap_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rxByte;
  end

  assign txStart   = tx_start_q;
  assign txByte    = tx_byte_q;
  assign fifoCount = count_q;
  assign overflow  = overflow_q;
  assign errCount  = err_q;
  assign stateDbg  = state_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
module tb_uart_echo_responder;

  localparam int FIFO_DEPTH = 4;
  localparam int START_WAIT = 2500;
  localparam int GAP_CYCLES = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  logic       clk = 1'b0;
  logic       rstN;
  logic       en;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxByte;
  logic       txBusy;
  logic       txDone;
  logic       txStart;
  logic [7:0] txByte;
  logic [2:0] fifoCount;
  logic       overflow;
  logic [7:0] errCount;
  logic [1:0] stateDbg;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_echo_responder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .START_WAIT(START_WAIT),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rstN(rstN), .en(en), .rxDone(rxDone), .rxErr(rxErr),
    .rxByte(rxByte), .txBusy(txBusy), .txDone(txDone), .txStart(txStart),
    .txByte(txByte), .fifoCount(fifoCount), .overflow(overflow),
    .errCount(errCount), .stateDbg(stateDbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rstN = 1'b0; en = 1'b1; rxDone = 1'b0; rxErr = 1'b0;
    rxByte = 8'h00; txBusy = 1'b0; txDone = 1'b0;
    tick; tick;
    rstN = 1'b1;
    tick;
  endtask

  // driver tasks
  task automatic rx_pulse(input logic [7:0] b, input logic err);
    rxByte = b; rxErr = err; rxDone = 1'b1;
    tick;
    rxDone = 1'b0; rxErr = 1'b0;
    tick;
  endtask

  // Acts as Uart8's transmitter for one byte.
  task automatic uart_serve(input int busy_len);
    int n = 0;
    while (txStart !== 1'b1 && n < 200) begin tick; n++; end
    n_vec++;
    if (txStart !== 1'b1) begin
      $display("FAIL serve_start: txStart=%b required 1 within 200 cycles", txStart);
      n_err++;
      return;
    end
    tick; tick;
    txBusy = 1'b1;
    tick;
    n_vec++;
    if (txStart !== 1'b0) begin
      $display("FAIL serve_start_drop: txStart=%b required 0", txStart); n_err++;
    end
    repeat (busy_len) tick;
    txBusy = 1'b0;
    tick; tick;
    n_vec++;
    if (stateDbg !== ST_IDLE) begin
      $display("FAIL serve_idle: state=%0d required %0d", stateDbg, ST_IDLE); n_err++;
    end
  endtask

  // scoreboard: every txStart rise must present the next expected byte,
  // and txByte must not move while in START or SEND
  initial begin
    logic       prev_start = 1'b0;
    logic [1:0] prev_st = ST_IDLE;
    logic [7:0] prev_byte = 8'h00;
    logic [7:0] e;
    forever begin
      tick;
      if (txStart === 1'b1 && prev_start === 1'b0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          $display("FAIL echo_unexpected: txByte=%02h with nothing expected", txByte);
          n_err++;
        end else begin
          e = exp_q.pop_front();
          if (txByte !== e) begin
            $display("FAIL echo_byte: txByte=%02h required %02h", txByte, e); n_err++;
          end
        end
      end
      if ((prev_st == ST_START || prev_st == ST_SEND) &&
          (stateDbg == ST_START || stateDbg == ST_SEND)) begin
        n_vec++;
        if (txByte !== prev_byte) begin
          $display("FAIL txbyte_stable: txByte=%02h required %02h", txByte, prev_byte);
          n_err++;
        end
      end
      prev_start = txStart;
      prev_st    = stateDbg;
      prev_byte  = txByte;
    end
  end

  task automatic test_reset;
    rstN = 1'b0; en = 1'b1; rxDone = 1'b1; rxErr = 1'b0;
    rxByte = 8'hA5; txBusy = 1'b1; txDone = 1'b0;
    tick; tick;
    n_vec++;
    if ({txStart, txByte, fifoCount, overflow, errCount, stateDbg} !== 23'd0) begin
      $display("FAIL reset_state: start=%b byte=%02h cnt=%0d ovf=%b err=%0d st=%0d required all 0",
               txStart, txByte, fifoCount, overflow, errCount, stateDbg);
      n_err++;
    end
    rxDone = 1'b0; txBusy = 1'b0;
    tick;
    rstN = 1'b1;
    tick;
  endtask

  task automatic test_single;
    exp_q.push_back(8'h8A);
    rxByte = 8'h8A; rxErr = 1'b0; rxDone = 1'b1;
    tick;
    n_vec++;
    if (fifoCount !== 3'd1 || txStart !== 1'b0) begin
      $display("FAIL single_push: cnt=%0d start=%b required 1 0", fifoCount, txStart); n_err++;
    end
    rxDone = 1'b0;
    tick;
    n_vec++;
    if (fifoCount !== 3'd0 || txStart !== 1'b1 || txByte !== 8'h8A) begin
      $display("FAIL single_pop: cnt=%0d start=%b byte=%02h required 0 1 8a",
               fifoCount, txStart, txByte);
      n_err++;
    end
    uart_serve(11520);
  endtask

  task automatic test_timeout;
    int n = 0;
    reset_dut;
    exp_q.push_back(8'h55);
    rx_pulse(8'h55, 1'b0);
    while (txStart === 1'b1 && n < START_WAIT + 100) begin n++; tick; end
    n_vec++;
    if (n != START_WAIT) begin
      $display("FAIL timeout_len: high %0d cycles required %0d", n, START_WAIT); n_err++;
    end
    n_vec++;
    if (errCount !== 8'd1 || stateDbg !== ST_IDLE || fifoCount !== 3'd0) begin
      $display("FAIL timeout_state: err=%0d st=%0d cnt=%0d required 1 0 0",
               errCount, stateDbg, fifoCount);
      n_err++;
    end
  endtask

  task automatic test_burst;
    txBusy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      rx_pulse(8'(i), 1'b0);
    end
    n_vec++;
    if (fifoCount !== 3'd4 || overflow !== 1'b0) begin
      $display("FAIL burst_fill: cnt=%0d ovf=%b required 4 0", fifoCount, overflow); n_err++;
    end
    rx_pulse(8'h06, 1'b0);
    n_vec++;
    if (fifoCount !== 3'd4 || overflow !== 1'b1) begin
      $display("FAIL burst_overflow: cnt=%0d ovf=%b required 4 1", fifoCount, overflow); n_err++;
    end
    txBusy = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) uart_serve(20 + $urandom_range(0, 10));
    n_vec++;
    if (exp_q.size() != 0 || overflow !== 1'b1) begin
      $display("FAIL burst_drain: left=%0d ovf=%b required 0 1", exp_q.size(), overflow); n_err++;
    end
  endtask

  task automatic test_disable;
    txBusy = 1'b1;
    exp_q.push_back(8'h21);
    for (int i = 0; i < 4; i++) rx_pulse(8'h21 + 8'(i), 1'b0);
    n_vec++;
    if (fifoCount !== 3'd3) begin
      $display("FAIL disable_pre: cnt=%0d required 3", fifoCount); n_err++;
    end
    en = 1'b0; rxByte = 8'h99; rxDone = 1'b1;
    tick;
    n_vec++;
    if (fifoCount !== 3'd0 || txStart !== 1'b0 || overflow !== 1'b0 ||
        errCount !== 8'd1 || stateDbg !== ST_IDLE) begin
      $display("FAIL disable_flush: cnt=%0d start=%b ovf=%b err=%0d st=%0d required 0 0 0 1 0",
               fifoCount, txStart, overflow, errCount, stateDbg);
      n_err++;
    end
    en = 1'b1;
    tick;
    rxDone = 1'b0; txBusy = 1'b0;
    repeat (20) tick;
    n_vec++;
    if (fifoCount !== 3'd0 || txStart !== 1'b0 || exp_q.size() != 0) begin
      $display("FAIL disable_quiet: cnt=%0d start=%b left=%0d required 0 0 0",
               fifoCount, txStart, exp_q.size());
      n_err++;
    end
  endtask

  task automatic test_simul;
    int n = 0;
    txBusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      rx_pulse(8'h10 + 8'(i), 1'b0);
    end
    n_vec++;
    if (fifoCount !== 3'd4) begin
      $display("FAIL simul_full: cnt=%0d required 4", fifoCount); n_err++;
    end
    txBusy = 1'b0;
    tick;
    while (stateDbg !== ST_IDLE && n < 20) begin n++; tick; end
    exp_q.push_back(8'hAA);
    rxByte = 8'hAA; rxDone = 1'b1;
    tick;
    rxDone = 1'b0;
    n_vec++;
    if (fifoCount !== 3'd4 || overflow !== 1'b0 || txStart !== 1'b1) begin
      $display("FAIL simul_pushpop: cnt=%0d ovf=%b start=%b required 4 0 1",
               fifoCount, overflow, txStart);
      n_err++;
    end
    for (int i = 0; i < 5; i++) uart_serve(8 + $urandom_range(0, 8));
    n_vec++;
    if (exp_q.size() != 0 || fifoCount !== 3'd0) begin
      $display("FAIL simul_drain: left=%0d cnt=%0d required 0 0", exp_q.size(), fifoCount);
      n_err++;
    end
  endtask

  task automatic test_error;
    int exp_err = 0;
    reset_dut;
    // asynchronous reset while a start request is pending
    exp_q.push_back(8'h3C);
    rx_pulse(8'h3C, 1'b0);
    #3;
    rstN = 1'b0;
    #1;
    n_vec++;
    if (txStart !== 1'b0 || fifoCount !== 3'd0 || stateDbg !== ST_IDLE) begin
      $display("FAIL async_reset: start=%b cnt=%0d st=%0d required 0 0 0",
               txStart, fifoCount, stateDbg);
      n_err++;
    end
    tick;
    rstN = 1'b1;
    tick;
    rx_pulse(8'h7A, 1'b1);
    exp_err = 1;
    n_vec++;
    if (errCount !== 8'(exp_err) || fifoCount !== 3'd0 || txStart !== 1'b0) begin
      $display("FAIL error_one: err=%0d cnt=%0d start=%b required 1 0 0",
               errCount, fifoCount, txStart);
      n_err++;
    end
    for (int i = 1; i < 300; i++) begin
      rx_pulse(8'($urandom_range(0, 255)), 1'b1);
      if (exp_err < 255) exp_err++;
    end
    n_vec++;
    if (errCount !== 8'(exp_err) || fifoCount !== 3'd0) begin
      $display("FAIL error_saturate: err=%0d cnt=%0d required %0d 0",
               errCount, fifoCount, exp_err);
      n_err++;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_timeout;
    test_burst;
    test_disable;
    test_simul;
    test_error;
    repeat (5) tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
